// File: rtl/pipe_front_regs.sv
// IF/ID, ID/EX and EX/MEM pipeline registers for the 5-stage MIPS-style core.
// Define PIPE_STALL_FLUSH_EN to add the stall and flush inputs.
module pipe_front_regs (
    input  logic        clk,
    input  logic        reset,
`ifdef PIPE_STALL_FLUSH_EN
    input  logic        if_id_stall,
    input  logic        id_ex_flush,
    input  logic        ex_mem_flush,
`endif
    input  logic [31:0] if_pc_plus1,
    input  logic [31:0] if_instr,
    output logic [31:0] id_pc_plus1,
    output logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_sign_ext,
    input  logic [9:0]  id_ctrl,
    output logic [31:0] ex_pc_plus1,
    output logic [31:0] ex_instr,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_sign_ext,
    output logic [4:0]  ex_rt_addr,
    output logic [4:0]  ex_rd_addr,
    output logic [9:0]  ex_ctrl,
    input  logic [31:0] ex_branch_target,
    input  logic [31:0] ex_alu_result,
    input  logic        ex_zero,
    input  logic [4:0]  ex_dest_addr,
    output logic [31:0] mem_branch_target,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_store_data,
    output logic        mem_zero,
    output logic [4:0]  mem_dest_addr,
    output logic [5:0]  mem_ctrl
);

    logic        w_stall;
    logic        w_id_bubble;
    logic        w_ex_flush;
    logic [5:0]  w_mem_ctrl;

    logic [31:0] r_id_pc_plus1;
    logic [31:0] r_id_instr;

    logic [31:0] r_ex_pc_plus1;
    logic [31:0] r_ex_instr;
    logic [31:0] r_ex_rs_data;
    logic [31:0] r_ex_rt_data;
    logic [31:0] r_ex_sign_ext;
    logic [4:0]  r_ex_rt_addr;
    logic [4:0]  r_ex_rd_addr;
    logic [9:0]  r_ex_ctrl;

    logic [31:0] r_mem_branch_target;
    logic [31:0] r_mem_alu_result;
    logic [31:0] r_mem_store_data;
    logic        r_mem_zero;
    logic [4:0]  r_mem_dest_addr;
    logic [5:0]  r_mem_ctrl;

`ifdef PIPE_STALL_FLUSH_EN
    assign w_stall     = if_id_stall;
    assign w_id_bubble = if_id_stall | id_ex_flush;
    assign w_ex_flush  = ex_mem_flush;
`else
    assign w_stall     = 1'b0;
    assign w_id_bubble = 1'b0;
    assign w_ex_flush  = 1'b0;
`endif

    // Drop regDest, ALUSrc and ALUOp; keep jump..MemWrite and RegWrite
    assign w_mem_ctrl = {r_ex_ctrl[8:4], r_ex_ctrl[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id_pc_plus1 <= '0;
            r_id_instr    <= '0;
        end else if (!w_stall) begin
            r_id_pc_plus1 <= if_pc_plus1;
            r_id_instr    <= if_instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_pc_plus1 <= '0;
            r_ex_instr    <= '0;
            r_ex_rs_data  <= '0;
            r_ex_rt_data  <= '0;
            r_ex_sign_ext <= '0;
            r_ex_rt_addr  <= '0;
            r_ex_rd_addr  <= '0;
            r_ex_ctrl     <= '0;
        end else begin
            r_ex_pc_plus1 <= r_id_pc_plus1;
            r_ex_instr    <= r_id_instr;
            r_ex_rs_data  <= id_rs_data;
            r_ex_rt_data  <= id_rt_data;
            r_ex_sign_ext <= id_sign_ext;
            r_ex_rt_addr  <= r_id_instr[20:16];
            r_ex_rd_addr  <= r_id_instr[15:11];
            r_ex_ctrl     <= w_id_bubble ? 10'd0 : id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_branch_target <= '0;
            r_mem_alu_result    <= '0;
            r_mem_store_data    <= '0;
            r_mem_zero          <= 1'b0;
            r_mem_dest_addr     <= '0;
            r_mem_ctrl          <= '0;
        end else begin
            r_mem_branch_target <= ex_branch_target;
            r_mem_alu_result    <= ex_alu_result;
            r_mem_store_data    <= r_ex_rt_data;
            r_mem_zero          <= w_ex_flush ? 1'b0 : ex_zero;
            r_mem_dest_addr     <= ex_dest_addr;
            r_mem_ctrl          <= w_ex_flush ? 6'd0 : w_mem_ctrl;
        end
    end

    assign id_pc_plus1       = r_id_pc_plus1;
    assign id_instr          = r_id_instr;
    assign ex_pc_plus1       = r_ex_pc_plus1;
    assign ex_instr          = r_ex_instr;
    assign ex_rs_data        = r_ex_rs_data;
    assign ex_rt_data        = r_ex_rt_data;
    assign ex_sign_ext       = r_ex_sign_ext;
    assign ex_rt_addr        = r_ex_rt_addr;
    assign ex_rd_addr        = r_ex_rd_addr;
    assign ex_ctrl           = r_ex_ctrl;
    assign mem_branch_target = r_mem_branch_target;
    assign mem_alu_result    = r_mem_alu_result;
    assign mem_store_data    = r_mem_store_data;
    assign mem_zero          = r_mem_zero;
    assign mem_dest_addr     = r_mem_dest_addr;
    assign mem_ctrl          = r_mem_ctrl;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Testbench for pipe_front_regs: directed cases plus randomized stream
// compared every cycle against a history-based reference model.
module tb_pipe_front_regs;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc_plus1, if_instr;
    logic [31:0] id_pc_plus1, id_instr;
    logic [31:0] id_rs_data, id_rt_data, id_sign_ext;
    logic [9:0]  id_ctrl;
    logic [31:0] ex_pc_plus1, ex_instr, ex_rs_data, ex_rt_data, ex_sign_ext;
    logic [4:0]  ex_rt_addr, ex_rd_addr;
    logic [9:0]  ex_ctrl;
    logic [31:0] ex_branch_target, ex_alu_result;
    logic        ex_zero;
    logic [4:0]  ex_dest_addr;
    logic [31:0] mem_branch_target, mem_alu_result, mem_store_data;
    logic        mem_zero;
    logic [4:0]  mem_dest_addr;
    logic [5:0]  mem_ctrl;

    int checks = 0;
    int errors = 0;

    pipe_front_regs dut (
        .clk               (clk),
        .reset             (reset),
`ifdef PIPE_STALL_FLUSH_EN
        .if_id_stall       (1'b0),
        .id_ex_flush       (1'b0),
        .ex_mem_flush      (1'b0),
`endif
        .if_pc_plus1       (if_pc_plus1),
        .if_instr          (if_instr),
        .id_pc_plus1       (id_pc_plus1),
        .id_instr          (id_instr),
        .id_rs_data        (id_rs_data),
        .id_rt_data        (id_rt_data),
        .id_sign_ext       (id_sign_ext),
        .id_ctrl           (id_ctrl),
        .ex_pc_plus1       (ex_pc_plus1),
        .ex_instr          (ex_instr),
        .ex_rs_data        (ex_rs_data),
        .ex_rt_data        (ex_rt_data),
        .ex_sign_ext       (ex_sign_ext),
        .ex_rt_addr        (ex_rt_addr),
        .ex_rd_addr        (ex_rd_addr),
        .ex_ctrl           (ex_ctrl),
        .ex_branch_target  (ex_branch_target),
        .ex_alu_result     (ex_alu_result),
        .ex_zero           (ex_zero),
        .ex_dest_addr      (ex_dest_addr),
        .mem_branch_target (mem_branch_target),
        .mem_alu_result    (mem_alu_result),
        .mem_store_data    (mem_store_data),
        .mem_zero          (mem_zero),
        .mem_dest_addr     (mem_dest_addr),
        .mem_ctrl          (mem_ctrl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One snapshot of every input, taken at each loading edge
    typedef struct {
        logic [31:0] if_pc;
        logic [31:0] if_instr;
        logic [31:0] id_rs;
        logic [31:0] id_rt;
        logic [31:0] id_se;
        logic [9:0]  id_ctrl;
        logic [31:0] ex_bt;
        logic [31:0] ex_alu;
        logic        ex_zero;
        logic [4:0]  ex_dest;
    } snap_t;

    snap_t h1, h2, zs;
    int    n_edges = 0;

    initial begin
        zs = '{default: '0};
        h1 = zs;
        h2 = zs;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n_edges = 0;
        end else begin
            h2 = h1;
            h1.if_pc    = if_pc_plus1;
            h1.if_instr = if_instr;
            h1.id_rs    = id_rs_data;
            h1.id_rt    = id_rt_data;
            h1.id_se    = id_sign_ext;
            h1.id_ctrl  = id_ctrl;
            h1.ex_bt    = ex_branch_target;
            h1.ex_alu   = ex_alu_result;
            h1.ex_zero  = ex_zero;
            h1.ex_dest  = ex_dest_addr;
            if (n_edges < 2) n_edges++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [5:0] mem_bits(input logic [9:0] c);
        // jump, branch, MemRead, MemtoReg, MemWrite, RegWrite
        return {c[8], c[7], c[6], c[5], c[4], c[0]};
    endfunction

    // Whole-block compare: a stage shows what entered k edges ago since
    // reset, or zero if fewer than k edges have happened.
    task automatic compare_model();
        snap_t a, b;
        a = (n_edges >= 1) ? h1 : zs;
        b = (n_edges >= 2) ? h2 : zs;
        chk("m_id_pc",    id_pc_plus1,           a.if_pc);
        chk("m_id_instr", id_instr,              a.if_instr);
        chk("m_ex_pc",    ex_pc_plus1,           b.if_pc);
        chk("m_ex_instr", ex_instr,              b.if_instr);
        chk("m_ex_rt_a",  32'(ex_rt_addr),       32'(b.if_instr[20:16]));
        chk("m_ex_rd_a",  32'(ex_rd_addr),       32'(b.if_instr[15:11]));
        chk("m_ex_rs",    ex_rs_data,            a.id_rs);
        chk("m_ex_rt",    ex_rt_data,            a.id_rt);
        chk("m_ex_se",    ex_sign_ext,           a.id_se);
        chk("m_ex_ctrl",  32'(ex_ctrl),          32'(a.id_ctrl));
        chk("m_mem_bt",   mem_branch_target,     a.ex_bt);
        chk("m_mem_alu",  mem_alu_result,        a.ex_alu);
        chk("m_mem_zero", 32'(mem_zero),         32'(a.ex_zero));
        chk("m_mem_dest", 32'(mem_dest_addr),    32'(a.ex_dest));
        chk("m_mem_st",   mem_store_data,        b.id_rt);
        chk("m_mem_ctrl", 32'(mem_ctrl),         32'(mem_bits(b.id_ctrl)));
    endtask

    always @(negedge clk) compare_model();

    task automatic chk_zero(input string tag);
        chk({tag, "_id_instr"}, id_instr, 32'h0);
        chk({tag, "_id_pc"},    id_pc_plus1, 32'h0);
        chk({tag, "_ex_instr"}, ex_instr, 32'h0);
        chk({tag, "_ex_ctrl"},  32'(ex_ctrl), 32'h0);
        chk({tag, "_ex_rt"},    ex_rt_data, 32'h0);
        chk({tag, "_mem_alu"},  mem_alu_result, 32'h0);
        chk({tag, "_mem_st"},   mem_store_data, 32'h0);
        chk({tag, "_mem_ctrl"}, 32'(mem_ctrl), 32'h0);
        chk({tag, "_mem_zero"}, 32'(mem_zero), 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        if_pc_plus1 = 0; if_instr = 0;
        id_rs_data = 0; id_rt_data = 0; id_sign_ext = 0; id_ctrl = 0;
        ex_branch_target = 0; ex_alu_result = 0; ex_zero = 0;
        ex_dest_addr = 0;
    endtask

    task automatic rand_inputs();
        if_pc_plus1 = $urandom; if_instr = $urandom;
        id_rs_data = $urandom; id_rt_data = $urandom;
        id_sign_ext = $urandom; id_ctrl = 10'($urandom);
        ex_branch_target = $urandom; ex_alu_result = $urandom;
        ex_zero = 1'($urandom); ex_dest_addr = 5'($urandom);
    endtask

    logic [31:0] stream [4];

    initial begin
        reset = 1'b0;
        if_pc_plus1 = '1; if_instr = '1;
        id_rs_data = '1; id_rt_data = '1; id_sign_ext = '1; id_ctrl = '1;
        ex_branch_target = '1; ex_alu_result = '1; ex_zero = 1'b1;
        ex_dest_addr = '1;
        #1 reset = 1'b1;
        #1 chk_zero("rst");

        step();
        chk_zero("rst_edge");
        clear_inputs();
        reset = 1'b0;

        if_instr = 32'h012A4020;
        if_pc_plus1 = 32'd1;
        step();
        chk("d_id_instr", id_instr, 32'h012A4020);
        clear_inputs();
        step();
        chk("d_ex_instr", ex_instr, 32'h012A4020);
        chk("d_ex_rt_addr", 32'(ex_rt_addr), 32'd10);
        chk("d_ex_rd_addr", 32'(ex_rd_addr), 32'd8);
        chk("d_ex_pc", ex_pc_plus1, 32'd1);

        id_ctrl = 10'b0001110001;
        id_rt_data = 32'h55;
        step();
        clear_inputs();
        step();
        chk("d_mem_ctrl", 32'(mem_ctrl), 32'b001111);
        chk("d_mem_store", mem_store_data, 32'h55);

        ex_alu_result = 32'h1234;
        ex_branch_target = 32'h40;
        ex_zero = 1'b1;
        ex_dest_addr = 5'd31;
        step();
        clear_inputs();
        chk("d_mem_alu", mem_alu_result, 32'h1234);
        chk("d_mem_bt", mem_branch_target, 32'h40);
        chk("d_mem_zero", 32'(mem_zero), 32'd1);
        chk("d_mem_dest", 32'(mem_dest_addr), 32'd31);

        stream[0] = 32'h8C220004;
        stream[1] = 32'hAC430008;
        stream[2] = 32'h00853022;
        stream[3] = 32'h10E8FFFD;
        for (int i = 0; i < 4; i++) begin
            if_instr = stream[i];
            step();
            chk("s_id", id_instr, stream[i]);
            if (i > 0) chk("s_ex", ex_instr, stream[i-1]);
        end
        clear_inputs();
        step();
        chk("s_ex_last", ex_instr, stream[3]);
        chk("s_id_drain", id_instr, 32'h0);

        rand_inputs();
        step();
        reset = 1'b1;
        #1 chk_zero("mid");
        step();
        chk_zero("mid_hold");
        reset = 1'b0;
        if_instr = 32'hCAFE0001;
        step();
        chk("refill_id", id_instr, 32'hCAFE0001);
        chk("refill_ex", ex_instr, 32'h0);

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            if (!reset && $urandom_range(0, 24) == 0) begin
                reset = 1'b1;
                #1 chk_zero("rnd_rst");
            end else if (reset && $urandom_range(0, 1) == 0) begin
                reset = 1'b0;
            end
            step();
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            step();
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
